// File: rtl/serializer_frame_scheduler_if.sv
// rtl/serializer_frame_scheduler_if.sv - requester/serial-lane bundle for the frame scheduler
//
// Purpose: groups the request bus and the serial-lane outputs of
// serializer_frame_scheduler into one interface.
//
// Signals:
//   REQ          requester -> scheduler  per-requester request level
//   PAR_IN       requester -> scheduler  packed words, requester i at [i*WORD_W +: WORD_W]
//   ACK          scheduler -> requester  one-hot, one-cycle capture pulse
//   SERIAL_OUT   scheduler -> link       serial data, LSB first
//   SERIAL_VALID scheduler -> link       frame bit qualifier
//   FRAME_START  scheduler -> link       high with bit 0 of each frame
//   BUSY         scheduler -> status     high outside IDLE
//   CUR_ID       scheduler -> status     index of the requester being serialized
//
// Modports: master = requester/link side, slave = scheduler side.

interface serializer_frame_scheduler_if #(
  parameter int NUM_REQ = 8,
  parameter int WORD_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*WORD_W-1:0] PAR_IN;
  logic [NUM_REQ-1:0]        ACK;
  logic                      SERIAL_OUT;
  logic                      SERIAL_VALID;
  logic                      FRAME_START;
  logic                      BUSY;
  logic [ID_W-1:0]           CUR_ID;

  modport master (
    output REQ,
    output PAR_IN,
    input  ACK,
    input  SERIAL_OUT,
    input  SERIAL_VALID,
    input  FRAME_START,
    input  BUSY,
    input  CUR_ID
  );

  modport slave (
    input  REQ,
    input  PAR_IN,
    output ACK,
    output SERIAL_OUT,
    output SERIAL_VALID,
    output FRAME_START,
    output BUSY,
    output CUR_ID
  );
endinterface

// File: rtl/serializer_frame_scheduler.sv
// rtl/serializer_frame_scheduler.sv - round-robin scheduler sharing one serial lane between requesters
//
// Purpose: arbitrates NUM_REQ parallel-word requesters round-robin, captures
// the granted word and shifts it out LSB first with valid/frame-start
// qualifiers, then idles GAP_CYCLES cycles before the next arbitration.
// Frame period with continuous requests is WORD_W + GAP_CYCLES + 1 cycles.
//
// Ports:
//   CLK    in   clock, rising edge
//   RESET  in   asynchronous active-low reset
//   bus    slave modport of serializer_frame_scheduler_if
//          (REQ, PAR_IN in; ACK, SERIAL_OUT, SERIAL_VALID, FRAME_START, BUSY, CUR_ID out)
//
// All outputs are registered; REQ and PAR_IN only reach outputs through flops.

module serializer_frame_scheduler #(
  parameter int NUM_REQ    = 8,
  parameter int WORD_W     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  serializer_frame_scheduler_if.slave   bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_shreg;
  logic [BC_W-1:0]     r_bitcnt;
  logic [3:0]          r_gapcnt;
  logic [ID_W-1:0]     r_last;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_serial_out;
  logic                r_serial_valid;
  logic                r_frame_start;
  logic                r_busy;
  logic [ID_W-1:0]     r_cur_id;

  logic                w_found;
  logic [ID_W-1:0]     w_gnt;
  logic [ID_W-1:0]     w_idx;
  int                  w_k;
  logic [WORD_W-1:0]   w_word;

  // Round-robin search: first set request starting just after the last
  // granted index, wrapping modulo NUM_REQ. The loop runs from the nearest
  // candidate outward and the found flag freezes the first hit.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    w_k     = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = int'(r_last) + i;
      if (w_k >= NUM_REQ) begin
        w_k = w_k - NUM_REQ;
      end
      w_idx = w_k[ID_W-1:0];
      if (!w_found && bus.REQ[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_word = bus.PAR_IN[w_gnt*WORD_W +: WORD_W];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_bitcnt       <= '0;
      r_gapcnt       <= '0;
      r_last         <= ID_W'(NUM_REQ - 1);
      r_ack          <= '0;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_busy         <= 1'b0;
      r_cur_id       <= '0;
    end else begin
      // ACK is a single-cycle pulse; only the grant edge sets it.
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          r_serial_out   <= 1'b0;
          r_serial_valid <= 1'b0;
          r_frame_start  <= 1'b0;
          if (w_found) begin
            r_ack    <= NUM_REQ'(1) << w_gnt;
            r_shreg  <= w_word;
            r_cur_id <= w_gnt;
            r_last   <= w_gnt;
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_SHIFT: begin
          r_serial_out   <= r_shreg[0];
          r_shreg        <= r_shreg >> 1;
          r_serial_valid <= 1'b1;
          r_frame_start  <= (r_bitcnt == '0);
          r_bitcnt       <= r_bitcnt + 1'b1;
          if (r_bitcnt == BC_W'(WORD_W - 1)) begin
            r_bitcnt <= '0;
            if (GAP_CYCLES == 0) begin
              // No gap: the following IDLE cycle is the only non-valid cycle.
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_gapcnt <= '0;
              r_state  <= ST_GAP;
            end
          end
        end

        ST_GAP: begin
          r_serial_out   <= 1'b0;
          r_serial_valid <= 1'b0;
          r_frame_start  <= 1'b0;
          r_gapcnt       <= r_gapcnt + 1'b1;
          if (r_gapcnt == 4'(GAP_CYCLES - 1)) begin
            r_gapcnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ACK          = r_ack;
  assign bus.SERIAL_OUT   = r_serial_out;
  assign bus.SERIAL_VALID = r_serial_valid;
  assign bus.FRAME_START  = r_frame_start;
  assign bus.BUSY         = r_busy;
  assign bus.CUR_ID       = r_cur_id;

endmodule

// File: tb/tb_serializer_frame_scheduler.sv
// tb/tb_serializer_frame_scheduler.sv - directed self-checking bench for serializer_frame_scheduler
module tb_serializer_frame_scheduler;

  localparam int N = 8;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic rst0_n;
  logic sel;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [W-1:0] words [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer_frame_scheduler_if #(.NUM_REQ(N), .WORD_W(W)) bus ();
  serializer_frame_scheduler_if #(.NUM_REQ(N), .WORD_W(W)) bus0 ();

  serializer_frame_scheduler #(.NUM_REQ(N), .WORD_W(W), .GAP_CYCLES(1)) u_dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  serializer_frame_scheduler #(.NUM_REQ(N), .WORD_W(W), .GAP_CYCLES(0)) u_dut0 (
    .CLK   (clk),
    .RESET (rst0_n),
    .bus   (bus0)
  );

  always_comb begin
    bus.PAR_IN  = '0;
    bus0.PAR_IN = '0;
    for (int i = 0; i < N; i++) begin
      bus.PAR_IN[i*W +: W]  = words[i];
      bus0.PAR_IN[i*W +: W] = words[i];
    end
  end

  logic [N-1:0] s_ack;
  logic         s_so, s_sv, s_fs, s_busy;
  logic [2:0]   s_id;
  assign s_ack  = sel ? bus0.ACK          : bus.ACK;
  assign s_so   = sel ? bus0.SERIAL_OUT   : bus.SERIAL_OUT;
  assign s_sv   = sel ? bus0.SERIAL_VALID : bus.SERIAL_VALID;
  assign s_fs   = sel ? bus0.FRAME_START  : bus.FRAME_START;
  assign s_busy = sel ? bus0.BUSY         : bus.BUSY;
  assign s_id   = sel ? bus0.CUR_ID       : bus.CUR_ID;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input int maxc, output int at);
    int n;
    n = 0;
    while (s_ack == '0 && n < maxc) begin
      tick();
      n++;
    end
    at = cyc;
    check({tag, "_ack_seen"}, 64'(s_ack != '0), 64'd1);
  endtask

  task automatic receive_frame(input string tag, input int churn, output logic [W-1:0] rx);
    int v_cnt, fs_cnt, ack_cnt;
    logic fs_first;
    v_cnt = 0; fs_cnt = 0; ack_cnt = 0; fs_first = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (churn >= 0) words[churn] = $urandom;
      tick();
      rx[i] = s_so;
      if (s_sv) v_cnt++;
      if (s_fs) fs_cnt++;
      if (s_ack != '0) ack_cnt++;
      if (i == 0) fs_first = s_fs;
    end
    check({tag, "_valid_bits"}, 64'(v_cnt), 64'(W));
    check({tag, "_fs_first"}, 64'(fs_first), 64'd1);
    check({tag, "_fs_count"}, 64'(fs_cnt), 64'd1);
    check({tag, "_ack_in_frame"}, 64'(ack_cnt), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check(tag, 64'({s_ack, s_so, s_sv, s_fs, s_busy, s_id}), 64'd0);
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] exp2;
    int t, prev, t6, exp_id, ack_cnt;

    sel = 1'b0;
    rst_n = 1'b0;
    rst0_n = 1'b0;
    bus.REQ = '0;
    bus0.REQ = '0;
    for (int i = 0; i < N; i++) words[i] = '0;
    repeat (2) tick();

    check_zero("reset_dut");
    sel = 1'b1;
    check_zero("reset_dut0");
    sel = 1'b0;

    // Single request, fixed bit pattern
    words[0] = 32'hA5A5_0F01;
    bus.REQ = 8'h01;
    rst_n = 1'b1;
    wait_ack("single", 5, t);
    check("single_ack", 64'(s_ack), 64'h01);
    check("single_id", 64'(s_id), 64'd0);
    check("single_busy", 64'(s_busy), 64'd1);
    bus.REQ = '0;
    receive_frame("single", -1, rx);
    check("single_bits", 64'(rx), 64'hA5A5_0F01);
    tick();
    check("single_gap_valid", 64'(s_sv), 64'd0);
    check("single_gap_out", 64'(s_so), 64'd0);
    check("single_idle_busy", 64'(s_busy), 64'd0);

    // Round-robin with all requesters high
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < N; i++) words[i] = (32'h0101_0101 * (i + 1)) ^ 32'h5A00_00C3;
    bus.REQ = 8'hFF;
    rst_n = 1'b1;
    prev = 0;
    for (int f = 0; f < 9; f++) begin
      exp_id = f % N;
      wait_ack("rr", 40, t);
      check("rr_ack", 64'(s_ack), 64'(1) << exp_id);
      check("rr_id", 64'(s_id), 64'(exp_id));
      if (f > 0) check("rr_spacing", 64'(t - prev), 64'd34);
      prev = t;
      if (f == 8) bus.REQ = 8'h40;
      receive_frame("rr", -1, rx);
      check("rr_bits", 64'(rx), 64'(words[exp_id]));
    end

    // Fairness wrap: after 6, REQ=0x41 gives 0 then 6
    wait_ack("wrap6", 10, t);
    check("wrap_first6", 64'(s_ack), 64'h40);
    bus.REQ = 8'h41;
    receive_frame("wrap6", -1, rx);
    wait_ack("wrap0", 10, t);
    check("wrap_then0", 64'(s_ack), 64'h01);
    receive_frame("wrap0", -1, rx);
    check("wrap0_bits", 64'(rx), 64'(words[0]));
    wait_ack("wrap6b", 10, t6);
    check("wrap_then6", 64'(s_ack), 64'h40);
    bus.REQ = '0;

    // Late REQ[3] and a 2-cycle REQ[5] pulse during SHIFT
    ack_cnt = 0;
    for (int i = 0; i < W; i++) begin
      tick();
      rx[i] = s_so;
      if (s_ack != '0) ack_cnt++;
      if (i == 5) bus.REQ[3] = 1'b1;
      if (i == 10) bus.REQ[5] = 1'b1;
      if (i == 12) bus.REQ[5] = 1'b0;
    end
    check("late_frame6_bits", 64'(rx), 64'(words[6]));
    check("late_no_ack_in_shift", 64'(ack_cnt), 64'd0);
    wait_ack("late3", 10, t);
    check("late_ack3_only", 64'(s_ack), 64'h08);
    check("late_after_gap", 64'(t - t6), 64'd34);
    bus.REQ = '0;
    receive_frame("late3", -1, rx);
    check("late3_bits", 64'(rx), 64'(words[3]));

    // Data isolation: word2 churns during its frame
    bus.REQ = 8'h04;
    wait_ack("iso", 10, t);
    check("iso_ack", 64'(s_ack), 64'h04);
    bus.REQ = '0;
    exp2 = words[2];
    receive_frame("iso", 2, rx);
    check("iso_bits", 64'(rx), 64'(exp2));

    // Reset at bit 10 of a frame
    bus.REQ = 8'h30;
    wait_ack("rst", 10, t);
    check("rst_ack4", 64'(s_ack), 64'h10);
    bus.REQ = '0;
    repeat (11) tick();
    check("rst_midframe_valid", 64'(s_sv), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async_zero");
    bus.REQ = 8'h31;
    tick();
    tick();
    rst_n = 1'b1;
    wait_ack("rst_after", 5, t);
    check("rst_first_grant0", 64'(s_ack), 64'h01);
    bus.REQ = '0;
    receive_frame("rst_after", -1, rx);
    check("rst_after_bits", 64'(rx), 64'(words[0]));

    // GAP_CYCLES=0 instance: back-to-back frames
    sel = 1'b1;
    bus0.REQ = 8'h03;
    rst0_n = 1'b1;
    wait_ack("g0", 5, prev);
    check("g0_ack0", 64'(s_ack), 64'h01);
    receive_frame("g0_f0", -1, rx);
    check("g0_f0_bits", 64'(rx), 64'(words[0]));
    tick();
    check("g0_gapcycle_valid", 64'(s_sv), 64'd0);
    check("g0_ack1", 64'(s_ack), 64'h02);
    check("g0_spacing", 64'(cyc - prev), 64'd33);
    receive_frame("g0_f1", -1, rx);
    check("g0_f1_bits", 64'(rx), 64'(words[1]));
    tick();
    check("g0_gap2_valid", 64'(s_sv), 64'd0);
    check("g0_ack_wrap", 64'(s_ack), 64'h01);
    repeat (11) tick();
    #2 rst0_n = 1'b0;
    #1 check_zero("g0_rst_async_zero");
    tick();
    tick();
    rst0_n = 1'b1;
    wait_ack("g0_rst_after", 5, t);
    check("g0_rst_first_grant0", 64'(s_ack), 64'h01);
    bus0.REQ = '0;
    receive_frame("g0_rst_after", -1, rx);
    check("g0_rst_after_bits", 64'(rx), 64'(words[0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serializer_frame_scheduler.md
# serializer_frame_scheduler

Round-robin scheduler that shares one bit-serial output lane between `NUM_REQ` parallel-word requesters. Each requester raises a request with a `WORD_W`-bit word. The scheduler grants one requester, captures its word, and shifts it out LSB-first with valid and frame-start qualifiers. It inserts a programmable idle gap between frames. It sits between the parallel sample sources and the serial link, replacing fixed-order sequencing of the sources with fair, on-demand arbitration.

## Interface
- `NUM_REQ`, 8, number of requesters (2..16)
- `WORD_W`, 32, bits per frame (2..64)
- `GAP_CYCLES`, 1, idle cycles after each frame before next arbitration (0..15)

- `CLK`  in  1  clock, rising edge
- `RESET`  in  1  asynchronous, active-low reset
- `REQ`  in  NUM_REQ  per-requester request level
- `PAR_IN`  in  NUM_REQ*WORD_W  packed words; requester i occupies bits [i*WORD_W +: WORD_W]
- `ACK`  out  NUM_REQ  one-hot, one-cycle pulse: word of requester i captured
- `SERIAL_OUT`  out  1  serial data, LSB first
- `SERIAL_VALID`  out  1  high while `SERIAL_OUT` carries a frame bit
- `FRAME_START`  out  1  high with bit 0 of each frame
- `BUSY`  out  1  high in every state except IDLE
- `CUR_ID`  out  clog2(NUM_REQ)  index of requester being serialized

## Operation
- States: IDLE, SHIFT, GAP.
- Reset (asynchronous, RESET=0):
  - Outputs: all outputs 0.
  - Internal: state IDLE; shift register, bit counter and gap counter 0.
  - Round-robin pointer `last` = NUM_REQ-1, so requester 0 has top priority first.
- IDLE:
  - When `REQ` is nonzero at a rising edge, grant the first set bit searching from `last`+1 upward, with modulo-NUM_REQ wrap.
  - On that edge: `ACK[g]`<=1, shift register <= word g, `CUR_ID`<=g, `last`<=g, bit counter <=0, state <= SHIFT.
- SHIFT:
  - Each edge: `SERIAL_OUT`<=shreg[0], shreg >>= 1, `SERIAL_VALID`<=1.
  - `FRAME_START`<=1 only when bit counter = 0.
  - Bit counter increments each edge. The edge that emits bit WORD_W-1 moves the state to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: `SERIAL_VALID`=0 and `SERIAL_OUT`=0. Stay GAP_CYCLES cycles, then go to IDLE.
- `ACK` deasserts on the edge after it is asserted.
- Data capture happens only at the grant edge. A requester may change `PAR_IN` and drop `REQ` from the cycle after `ACK`. `PAR_IN` changes during SHIFT have no effect.
- `REQ` is a level:
  - A requester still high after its `ACK` is a new request and re-enters arbitration behind the others.
  - `REQ` dropped before grant means no service and no `ACK`.
- `REQ` is not sampled outside IDLE. Requests arriving during SHIFT or GAP wait; nothing is queued.
- `CUR_ID` holds its value until the next grant.
- Reset asserted mid-frame: frame aborted immediately, outputs 0. No `ACK` replay; the requester must re-request.

## Timing
- Grant at edge k (IDLE, REQ≠0):
  - `ACK` high during cycle k..k+1.
  - Bit 0 on `SERIAL_OUT` after edge k+1, with `FRAME_START`=1.
  - Bit WORD_W-1 after edge k+WORD_W.
- `SERIAL_VALID` falls at edge k+WORD_W+1.
- The next grant edge is at the earliest k+WORD_W+GAP_CYCLES+1.
- Frame period with continuous requests is WORD_W+GAP_CYCLES+1 cycles, i.e. 34 at defaults.
- Serial output is gap-free between frames only if GAP_CYCLES=0. Even then, one non-valid cycle (the IDLE grant cycle) separates frames.
- All outputs are registered. There is no combinational path from `REQ` or `PAR_IN` to any output.

## Test plan
- Single request: reset; REQ=8'h01, PAR_IN word0=32'hA5A5_0F01.
  - Required: `ACK`=8'h01 for one cycle.
  - Required: 32 valid bits 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 (LSB first), with `FRAME_START` on the first bit only.
- Round-robin: REQ=8'hFF held, distinct words per requester.
  - Required: grant order 0,1,…,7,0, with each frame's bits matching its word.
  - Required: grant edges spaced 34 cycles apart.
- Fairness wrap: after a grant to 6, REQ=8'h41.
  - Required: next grant 0, then 6.
- Late and withdrawn requests:
  - REQ[3] raised mid-frame: granted only after GAP, in IDLE.
  - REQ[5] pulsed for 2 cycles during SHIFT: never acknowledged.
- Data isolation: change word2 every cycle during its SHIFT.
  - Required: the serialized bits equal the word present at the grant edge.
- Reset mid-frame and gap: assert RESET at bit 10.
  - Required: all outputs 0 asynchronously, and after release the first grant goes to requester 0.
  - Repeat with GAP_CYCLES=0: exactly one non-valid cycle between back-to-back frames.
